// File: rtl/bcd_seg_display_if.sv
// Request/result bundle between a datapath field register and one multi-digit
// 7-segment display converter.
interface bcd_seg_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  load;
    logic [WIDTH-1:0]      value;
    logic                  blink_en;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   seg;

    modport master (output load, value, blink_en,
                    input  busy, done, overflow, bcd, seg);
    modport slave  (input  load, value, blink_en,
                    output busy, done, overflow, bcd, seg);
endinterface

// File: rtl/bcd_seg_display.sv
// Iterative binary-to-BCD (double-dabble) converter driving DIGITS active-low
// 7-segment digits with leading-zero blanking, overflow dashes and blink.
module bcd_seg_display #(
    parameter int WIDTH     = 8,
    parameter int DIGITS    = 3,
    parameter int BLANK_LZ  = 1,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    bcd_seg_display_if.slave  bus
);
    // Scratch must hold every decimal digit WIDTH bits can produce, and at
    // least DIGITS nibbles so the low-digit slice always exists.
    localparam int NIB_MIN = (WIDTH * 302 + 999) / 1000 + 1;
    localparam int SN      = (NIB_MIN > DIGITS) ? NIB_MIN : DIGITS;
    localparam int CW      = $clog2(WIDTH + 1);
    localparam int BW      = $clog2(BLINK_DIV);

    // 10^DIGITS, saturated to 2^WIDTH (unreachable) when it exceeds the input range.
    function automatic logic [WIDTH:0] pow10_sat();
        logic [WIDTH+4:0] p;
        p = {{(WIDTH+4){1'b0}}, 1'b1};
        for (int i = 0; i < DIGITS; i++)
            if (p[WIDTH+4:WIDTH] == 5'd0) p = (p << 3) + (p << 1);
        return (p[WIDTH+4:WIDTH] == 5'd0) ? p[WIDTH:0] : {1'b1, {WIDTH{1'b0}}};
    endfunction

    localparam logic [WIDTH:0] OVF_LIMIT = pow10_sat();

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0011000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] reset_seg();
        logic [7*DIGITS-1:0] s;
        s = (BLANK_LZ != 0) ? {DIGITS{7'b1111111}} : {DIGITS{7'b1000000}};
        s[6:0] = 7'b1000000;
        return s;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    sreg;
    logic [4*SN-1:0]     scratch;
    logic [CW-1:0]       cnt;
    logic                ovf_pend;
    logic                busy_r;
    logic                done_r;
    logic                ovf_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [7*DIGITS-1:0] seg_r;
    logic [BW-1:0]       blink_cnt;
    logic                phase;

    logic [4*SN-1:0]     adj;
    logic [4*SN-1:0]     scratch_nxt;
    logic [7*DIGITS-1:0] seg_nxt;
    logic                lead;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < SN; i++)
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        scratch_nxt = (adj << 1) | {{(4*SN-1){1'b0}}, sreg[WIDTH-1]};
    end

    // Walk from the top digit down; blanking stops at the first nonzero digit.
    always_comb begin
        seg_nxt = '1;
        lead    = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (ovf_pend)
                seg_nxt[7*d +: 7] = 7'b0111111;
            else if (BLANK_LZ != 0 && lead && d != 0 && scratch[4*d +: 4] == 4'd0)
                seg_nxt[7*d +: 7] = 7'b1111111;
            else begin
                seg_nxt[7*d +: 7] = seg7(scratch[4*d +: 4]);
                lead              = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
            bcd_r     <= '0;
            seg_r     <= reset_seg();
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.load) begin
                    sreg     <= bus.value;
                    scratch  <= '0;
                    cnt      <= CW'(WIDTH);
                    ovf_pend <= ({1'b0, bus.value} >= OVF_LIMIT);
                    busy_r   <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    sreg    <= sreg << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= UPDATE;
                end
                UPDATE: begin
                    bcd_r  <= scratch[4*DIGITS-1:0];
                    seg_r  <= seg_nxt;
                    ovf_r  <= ovf_pend;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (!bus.blink_en) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
    assign bus.bcd      = bcd_r;
    assign bus.seg      = phase ? '1 : seg_r;
endmodule
